// File: rtl/spc_pcx_req_sched_if.sv
// PCX request scheduler bus: two packet sources, the registered PCX request/data stream and grant returns.
// PCX_WIDTH (payload width) defaults to 124 unless defined before this file.
`ifndef PCX_WIDTH
`define PCX_WIDTH 124
`endif

interface spc_pcx_req_sched_if;
  logic                   src0_vld;
  logic [4:0]             src0_dest;
  logic                   src0_atom;
  logic [`PCX_WIDTH-1:0]  src0_data;
  logic                   src0_ack;

  logic                   src1_vld;
  logic [4:0]             src1_dest;
  logic                   src1_atom;
  logic [`PCX_WIDTH-1:0]  src1_data;
  logic                   src1_ack;

  logic [4:0]             spc_pcx_req_pq;
  logic                   spc_pcx_atom_pq;
  logic [`PCX_WIDTH-1:0]  spc_pcx_data_pa;
  logic [4:0]             pcx_spc_grant_px;

  modport master (
    input  src0_vld, src0_dest, src0_atom, src0_data,
    input  src1_vld, src1_dest, src1_atom, src1_data,
    input  pcx_spc_grant_px,
    output src0_ack, src1_ack,
    output spc_pcx_req_pq, spc_pcx_atom_pq, spc_pcx_data_pa
  );

  modport slave (
    output src0_vld, src0_dest, src0_atom, src0_data,
    output src1_vld, src1_dest, src1_atom, src1_data,
    output pcx_spc_grant_px,
    input  src0_ack, src1_ack,
    input  spc_pcx_req_pq, spc_pcx_atom_pq, spc_pcx_data_pa
  );
endinterface

// File: rtl/spc_pcx_req_sched.sv
// Two-source round-robin PCX request scheduler with per-destination credits and atomic-pair locking.
// Optional sticky credit-overflow check enabled by defining SPC_PCX_SCHED_CREDIT_CHK_EN.
`ifndef PCX_WIDTH
`define PCX_WIDTH 124
`endif

module spc_pcx_req_sched #(
  parameter int CREDIT_MAX = 2
) (
  input  logic                 rclk,
  input  logic                 arst_l,
  spc_pcx_req_sched_if.master  bus,
  output logic                 sched_credit_err
);

  localparam int CW = $clog2(CREDIT_MAX + 1);
  localparam logic [CW-1:0] CRED_FULL = CW'(CREDIT_MAX);
  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] ATOM_LOCK = 1'b1;

  logic [CW-1:0]          credit [5];
  logic [0:0]             state;
  logic                   lock_src;
  logic [4:0]             lock_dest;
  logic                   rr_pri;
  logic [4:0]             req_q;
  logic                   atom_q;
  logic [`PCX_WIDTH-1:0]  data_s1;
  logic [`PCX_WIDTH-1:0]  data_q;

  logic [CW-1:0]          cred0, cred1;
  logic                   elig0, elig1;
  logic                   ack_any, sel;
  logic [4:0]             sel_dest;
  logic                   sel_atom;
  logic [`PCX_WIDTH-1:0]  sel_data;

  function automatic logic onehot5(input logic [4:0] v);
    return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
  endfunction

  // Eligibility looks only at registered credits; a same-cycle grant is not bypassed.
  always_comb begin
    cred0 = '0;
    cred1 = '0;
    for (int d = 0; d < 5; d++) begin
      if (bus.src0_dest[d]) cred0 = cred0 | credit[d];
      if (bus.src1_dest[d]) cred1 = cred1 | credit[d];
    end
    elig0 = bus.src0_vld && onehot5(bus.src0_dest) &&
            (32'(cred0) >= (bus.src0_atom ? 32'd2 : 32'd1));
    elig1 = bus.src1_vld && onehot5(bus.src1_dest) &&
            (32'(cred1) >= (bus.src1_atom ? 32'd2 : 32'd1));

    ack_any = 1'b0;
    sel     = 1'b0;
    if (!arst_l) begin
      ack_any = 1'b0;
    end else if (state == ATOM_LOCK) begin
      sel     = lock_src;
      ack_any = lock_src ? bus.src1_vld : bus.src0_vld;
    end else if (elig0 && elig1) begin
      ack_any = 1'b1;
      sel     = rr_pri;
    end else if (elig0 || elig1) begin
      ack_any = 1'b1;
      sel     = elig1;
    end

    // The second half of an atomic pair rides on the credit reserved by the first.
    sel_data = sel ? bus.src1_data : bus.src0_data;
    sel_dest = (state == ATOM_LOCK) ? lock_dest : (sel ? bus.src1_dest : bus.src0_dest);
    sel_atom = (state == IDLE) && (sel ? bus.src1_atom : bus.src0_atom);
  end

  assign bus.src0_ack        = ack_any && !sel;
  assign bus.src1_ack        = ack_any && sel;
  assign bus.spc_pcx_req_pq  = req_q;
  assign bus.spc_pcx_atom_pq = atom_q;
  assign bus.spc_pcx_data_pa = data_q;

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      req_q   <= '0;
      atom_q  <= 1'b0;
      data_s1 <= '0;
      data_q  <= '0;
    end else begin
      req_q   <= ack_any ? sel_dest : 5'd0;
      atom_q  <= ack_any && sel_atom;
      data_s1 <= ack_any ? sel_data : '0;
      data_q  <= data_s1;
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state     <= IDLE;
      lock_src  <= 1'b0;
      lock_dest <= '0;
      rr_pri    <= 1'b0;
    end else if (ack_any) begin
      if (state == ATOM_LOCK) begin
        state <= IDLE;
      end else begin
        rr_pri <= ~sel;
        if (sel_atom) begin
          state     <= ATOM_LOCK;
          lock_src  <= sel;
          lock_dest <= sel_dest;
        end
      end
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      for (int d = 0; d < 5; d++) credit[d] <= CRED_FULL;
    end else begin
      for (int d = 0; d < 5; d++) begin
        if ((ack_any && sel_dest[d]) && !bus.pcx_spc_grant_px[d])
          credit[d] <= credit[d] - CW'(1);
        else if (bus.pcx_spc_grant_px[d] && !(ack_any && sel_dest[d]) && (credit[d] != CRED_FULL))
          credit[d] <= credit[d] + CW'(1);
      end
    end
  end

`ifdef SPC_PCX_SCHED_CREDIT_CHK_EN
  logic [4:0] full_mask;

  always_comb begin
    full_mask = '0;
    for (int d = 0; d < 5; d++) full_mask[d] = (credit[d] == CRED_FULL);
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l)
      sched_credit_err <= 1'b0;
    else if (|(bus.pcx_spc_grant_px & full_mask))
      sched_credit_err <= 1'b1;
  end
`else
  assign sched_credit_err = 1'b0;
`endif

endmodule

// File: tb/tb_spc_pcx_req_sched.sv
// Randomized self-checking bench for spc_pcx_req_sched against a behavioural credit/arbitration model.
`ifndef PCX_WIDTH
`define PCX_WIDTH 124
`endif

module tb_spc_pcx_req_sched;
  localparam int CREDIT_MAX = 2;
  localparam int W = `PCX_WIDTH;

  logic rclk = 1'b0;
  logic arst_l = 1'b0;
  logic sched_credit_err;

  spc_pcx_req_sched_if bus();

  spc_pcx_req_sched #(.CREDIT_MAX(CREDIT_MAX)) dut (
    .rclk             (rclk),
    .arst_l           (arst_l),
    .bus              (bus),
    .sched_credit_err (sched_credit_err)
  );

  always #5 rclk = ~rclk;

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus for the current cycle.
  bit          s_vld   [2];
  logic [4:0]  s_dest  [2];
  bit          s_atom  [2];
  logic [W-1:0] s_data [2];
  logic [4:0]  s_grant;

  // Reference model state.
  int          cred [5];
  bit          locked;
  int          lock_src;
  logic [4:0]  lock_dest;
  int          pri;
  logic [4:0]  m_req;
  bit          m_atom;
  logic [W-1:0] m_stage, m_data;
  bit          m_err;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.src0_vld  = s_vld[0];  bus.src0_dest = s_dest[0];
    bus.src0_atom = s_atom[0]; bus.src0_data = s_data[0];
    bus.src1_vld  = s_vld[1];  bus.src1_dest = s_dest[1];
    bus.src1_atom = s_atom[1]; bus.src1_data = s_data[1];
    bus.pcx_spc_grant_px = s_grant;
  endtask

  task automatic clear_inputs();
    for (int s = 0; s < 2; s++) begin
      s_vld[s] = 1'b0; s_dest[s] = '0; s_atom[s] = 1'b0; s_data[s] = '0;
    end
    s_grant = '0;
    drive();
  endtask

  task automatic applyStimulus();
    for (int s = 0; s < 2; s++) begin
      s_vld[s]  = ($urandom_range(0, 3) != 0);
      s_dest[s] = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'(1 << $urandom_range(0, 4));
      s_atom[s] = ($urandom_range(0, 3) == 0);
      s_data[s] = W'({$urandom, $urandom, $urandom, $urandom});
    end
    for (int d = 0; d < 5; d++) s_grant[d] = ($urandom_range(0, 7) == 0);
    drive();
  endtask

  task automatic model_reset();
    for (int d = 0; d < 5; d++) cred[d] = CREDIT_MAX;
    locked = 0; lock_src = 0; lock_dest = '0; pri = 0;
    m_req = '0; m_atom = 0; m_stage = '0; m_data = '0; m_err = 0;
  endtask

  function automatic int dest_index(input logic [4:0] v);
    for (int d = 0; d < 5; d++) if (v[d]) return d;
    return 0;
  endfunction

  function automatic bit eligible(input int s);
    if (!s_vld[s] || $countones(s_dest[s]) != 1) return 0;
    return cred[dest_index(s_dest[s])] >= (s_atom[s] ? 2 : 1);
  endfunction

  // Which source the scheduler should accept this cycle, -1 for none.
  function automatic int pick();
    if (locked) return s_vld[lock_src] ? lock_src : -1;
    if (eligible(pri)) return pri;
    if (eligible(1 - pri)) return 1 - pri;
    return -1;
  endfunction

  task automatic model_advance(input int win);
    logic [4:0] idest;
    bit iatom;
    idest = '0; iatom = 0;
    if (win >= 0) begin
      idest = locked ? lock_dest : s_dest[win];
      iatom = locked ? 1'b0 : s_atom[win];
    end
`ifdef SPC_PCX_SCHED_CREDIT_CHK_EN
    for (int d = 0; d < 5; d++) if (s_grant[d] && cred[d] == CREDIT_MAX) m_err = 1;
`endif
    for (int d = 0; d < 5; d++) begin
      cred[d] = cred[d] - ((win >= 0 && idest[d]) ? 1 : 0) + (s_grant[d] ? 1 : 0);
      if (cred[d] > CREDIT_MAX) cred[d] = CREDIT_MAX;
    end
    m_data  = m_stage;
    m_stage = (win >= 0) ? s_data[win] : '0;
    m_req   = idest;
    m_atom  = iatom;
    if (win >= 0) begin
      if (locked) begin
        locked = 0;
      end else begin
        pri = 1 - win;
        if (iatom) begin locked = 1; lock_src = win; lock_dest = idest; end
      end
    end
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic run_cycle(input bit rnd);
    int win;
    if (rnd) applyStimulus(); else drive();
    @(negedge rclk);
    win = pick();
    checkOutput("src0_ack", 128'(bus.src0_ack), 128'(win == 0));
    checkOutput("src1_ack", 128'(bus.src1_ack), 128'(win == 1));
    checkOutput("req_pq", 128'(bus.spc_pcx_req_pq), 128'(m_req));
    checkOutput("atom_pq", 128'(bus.spc_pcx_atom_pq), 128'(m_atom));
    checkOutput("data_pa", 128'(bus.spc_pcx_data_pa), 128'(m_data));
    checkOutput("credit_err", 128'(sched_credit_err), 128'(m_err));
    model_advance(win);
    @(posedge rclk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_ack0"}, 128'(bus.src0_ack), 128'(0));
    checkOutput({tag, "_ack1"}, 128'(bus.src1_ack), 128'(0));
    checkOutput({tag, "_req"}, 128'(bus.spc_pcx_req_pq), 128'(0));
    checkOutput({tag, "_atom"}, 128'(bus.spc_pcx_atom_pq), 128'(0));
    checkOutput({tag, "_data"}, 128'(bus.spc_pcx_data_pa), 128'(0));
    checkOutput({tag, "_err"}, 128'(sched_credit_err), 128'(0));
  endtask

  initial begin
    int budget;
    clear_inputs();
    model_reset();
    arst_l = 1'b0;
    repeat (2) @(posedge rclk);
    #1;
    s_vld[0] = 1; s_dest[0] = 5'b00100; s_vld[1] = 1; s_dest[1] = 5'b00001;
    drive();
    #2;
    check_all_zero("reset");
    clear_inputs();
    @(posedge rclk);
    #1;
    arst_l = 1'b1;

    // Directed single packet to bank 2, then two idle cycles to watch the pipeline.
    s_vld[0] = 1; s_dest[0] = 5'b00100; s_data[0] = W'(128'hA5A5_0123_4567_89AB_CDEF);
    run_cycle(0);
    clear_inputs();
    run_cycle(0);
    run_cycle(0);

    repeat (1500) run_cycle(1);

    // Reset while an atomic pair is half issued.
    budget = 0;
    while (!locked && budget < 300) begin
      run_cycle(1);
      budget++;
    end
    arst_l = 1'b0;
    applyStimulus();
    #1;
    check_all_zero("midreset");
    clear_inputs();
    model_reset();
    @(posedge rclk);
    #1;
    arst_l = 1'b1;

    repeat (600) run_cycle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
